// File: rtl/max_pool2x2_stream.sv
// Streaming 2x2 / stride-2 max pooler for a single feature-map channel.
// Pixels arrive in raster order, one per accepted beat. The horizontal pair
// maximum of each even row is parked in a half-width line buffer. The matching
// pair on the following odd row is combined with it to form the window maximum.
module max_pool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);

    // Pooled output grid; a trailing odd column/row is counted but never pooled.
    localparam int POOL_W = IMG_W / 2;
    localparam int POOL_H = IMG_H / 2;

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_AW = (POOL_W > 1) ? $clog2(POOL_W) : 1;

    localparam logic [COL_W-1:0] COL_MAX      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX      = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'(2 * POOL_W - 1);
    localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'(2 * POOL_H - 1);

    // Larger of two pixels under the configured signedness. On a tie either
    // operand gives the same bits, so the choice does not matter.
    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic a_ge_b;
        if (SIGNED != 0) begin
            a_ge_b = ($signed(a) >= $signed(b));
        end else begin
            a_ge_b = (a >= b);
        end
        return a_ge_b ? a : b;
    endfunction

    // Raster position of the pixel currently on in_data.
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    // Even-column pixel waiting for its odd-column partner.
    logic [DATA_W-1:0] hold;

    // Pair maxima of the last even row, one entry per pooled column.
    logic [DATA_W-1:0] linebuf [POOL_W];

    logic              accept;
    logic              col_end;
    logic              row_end;
    logic [LB_AW-1:0]  lb_idx;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] win_max;
    logic              lb_wr;
    logic              emit;
    logic              emit_last;
    logic              frame_end;

    // Decode the current beat: acceptance, window position and the maxima.
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        accept    = 1'b0;
        col_end   = 1'b0;
        row_end   = 1'b0;
        lb_idx    = '0;
        pair_max  = '0;
        win_max   = '0;
        lb_wr     = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        frame_end = 1'b0;

        // clear wins over a coincident pixel, which is simply dropped.
        accept    = in_valid & ~clear;
        col_end   = (col == COL_MAX);
        row_end   = (row == ROW_MAX);
        lb_idx    = LB_AW'(col >> 1);
        pair_max  = max2(hold, in_data);
        win_max   = max2(linebuf[lb_idx], pair_max);

        // Odd column closes a horizontal pair: even rows park it, odd rows
        // complete the 2x2 window. Odd columns always fall inside the
        // pooled area, so no extra range check is needed.
        lb_wr     = accept & col[0] & ~row[0];
        emit      = accept & col[0] & row[0];
        emit_last = emit & (col == WIN_COL_LAST) & (row == WIN_ROW_LAST);
        frame_end = accept & col_end & row_end;
    end

    // Raster counters: col wraps into row, row wraps at frame end.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Capture the even-column pixel of each horizontal pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (clear) begin
            hold <= '0;
        end else if (accept && !col[0]) begin
            hold <= in_data;
        end
    end

    // Line buffer write port; read combinationally above on odd rows only.
    // NOTE: the line buffer has no reset so it can map to distributed RAM;
    // every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    // Registered outputs: single-cycle pulses, out_data holds between them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= emit;
            out_last   <= emit_last;
            frame_done <= frame_end;
            if (emit) begin
                out_data <= win_max;
            end
        end
    end

endmodule

// File: tb/tb_max_pool2x2_stream.sv
// Scoreboard bench for max_pool2x2_stream. Four instances cover the
// configurations exercised: 4x4 unsigned, 2x2 signed, 2x2 unsigned and 5x3
// unsigned. The driver pushes hand-computed expectations (value, last flag,
// arrival cycle) when it issues the triggering pixel; a negedge monitor pops
// and compares whenever an instance raises out_valid or frame_done.
module tb_max_pool2x2_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [3:0]    iv;
    logic [DW-1:0] in_data;
    logic [3:0]    ov;
    logic [3:0]    ol;
    logic [3:0]    fd;
    logic [DW-1:0] od [4];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int sel;
        int data;
        bit last;
        int cyc;
    } out_exp_t;

    typedef struct {
        int sel;
        int cyc;
    } fd_exp_t;

    out_exp_t outq [$];
    fd_exp_t  fdq  [$];

    // Hand-computed maxima of a 4x4 frame of base+0..base+15, relative to base,
    // placed at the index of the pixel that completes each window.
    int exp4 [16] = '{-1, -1, -1, -1, -1, 5, -1, 7, -1, -1, -1, -1, -1, 13, -1, 15};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    max_pool2x2_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .SIGNED(0)) u_u4x4 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(iv[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .frame_done(fd[0])
    );

    max_pool2x2_stream #(.DATA_W(DW), .IMG_W(2), .IMG_H(2), .SIGNED(1)) u_s2x2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(iv[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .frame_done(fd[1])
    );

    max_pool2x2_stream #(.DATA_W(DW), .IMG_W(2), .IMG_H(2), .SIGNED(0)) u_u2x2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(iv[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]), .frame_done(fd[2])
    );

    max_pool2x2_stream #(.DATA_W(DW), .IMG_W(5), .IMG_H(3), .SIGNED(0)) u_u5x3 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(iv[3]), .in_data(in_data),
        .out_valid(ov[3]), .out_data(od[3]), .out_last(ol[3]), .frame_done(fd[3])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Present one pixel to instance sel for one cycle and register what it
    // should produce. exp_out < 0 means no pooled output is due.
    task automatic send_pixel(input int sel, input int data, input int exp_out,
                              input bit exp_last, input bit exp_fd);
        out_exp_t oe;
        fd_exp_t  fe;
        @(posedge clk);
        #1;
        iv      = '0;
        iv[sel] = 1'b1;
        in_data = DW'(data);
        if (exp_out >= 0) begin
            oe.sel  = sel;
            oe.data = exp_out;
            oe.last = exp_last;
            oe.cyc  = cyc + 1;
            outq.push_back(oe);
        end
        if (exp_fd) begin
            fe.sel = sel;
            fe.cyc = cyc + 1;
            fdq.push_back(fe);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        iv = '0;
    endtask

    // Full 4x4 frame of base+0..base+15 on the 4x4 instance, optionally with
    // random bubbles giving roughly a 40% in_valid duty.
    task automatic send_4x4(input int base, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int g = 0;
                while (($urandom_range(0, 99) >= 40) && (g < 8)) begin
                    idle();
                    g++;
                end
            end
            send_pixel(0, base + i, (exp4[i] >= 0) ? base + exp4[i] : -1,
                       (i == 15), (i == 15));
        end
    endtask

    // Monitor: every output event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 4; s++) begin
                if (ov[s]) begin
                    if (outq.size() == 0) begin
                        check($sformatf("unexpected_out_valid_dut%0d", s), 1, 0);
                    end else begin
                        out_exp_t e;
                        e = outq.pop_front();
                        check("out_dut_sel", s, e.sel);
                        check("out_data", int'(od[s]), e.data);
                        check("out_last", int'(ol[s]), int'(e.last));
                        check("out_latency_cycle", cyc, e.cyc);
                    end
                end else if (ol[s]) begin
                    check($sformatf("out_last_without_valid_dut%0d", s), 1, 0);
                end
                if (fd[s]) begin
                    if (fdq.size() == 0) begin
                        check($sformatf("unexpected_frame_done_dut%0d", s), 1, 0);
                    end else begin
                        fd_exp_t f;
                        f = fdq.pop_front();
                        check("frame_done_dut_sel", s, f.sel);
                        check("frame_done_cycle", cyc, f.cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        iv      = '0;
        in_data = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(ov), 0);
        check("reset_out_last", int'(ol), 0);
        check("reset_frame_done", int'(fd), 0);
        check("reset_out_data_4x4", int'(od[0]), 0);
        check("reset_out_data_5x3", int'(od[3]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 4x4 unsigned, back-to-back: 5, 7, 13, 15(last) with frame_done.
        send_4x4(0, 1'b0);
        idle();
        idle();

        // 2x2 window {FF, 01, 80, 00}: signed max is 0x01, unsigned max 0xFF.
        send_pixel(1, 8'hFF, -1, 1'b0, 1'b0);
        send_pixel(1, 8'h01, -1, 1'b0, 1'b0);
        send_pixel(1, 8'h80, -1, 1'b0, 1'b0);
        send_pixel(1, 8'h00, 8'h01, 1'b1, 1'b1);
        idle();
        send_pixel(2, 8'hFF, -1, 1'b0, 1'b0);
        send_pixel(2, 8'h01, -1, 1'b0, 1'b0);
        send_pixel(2, 8'h80, -1, 1'b0, 1'b0);
        send_pixel(2, 8'h00, 8'hFF, 1'b1, 1'b1);
        idle();
        idle();

        // 5x3, pixels 0..14: windows end at pixels 6 and 8; col 4 and row 2
        // are ignored; frame_done follows pixel 14.
        for (int i = 0; i < 15; i++) begin
            send_pixel(3, i, (i == 6) ? 6 : ((i == 8) ? 8 : -1), (i == 8), (i == 14));
        end
        idle();
        idle();

        // 4x4 with random bubbles: same results, same 1-cycle latency.
        send_4x4(0, 1'b1);
        idle();
        idle();

        // Reset after 6 pixels: the window completed by pixel 5 is lost.
        for (int i = 0; i < 6; i++) begin
            send_pixel(0, i, -1, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        iv  = '0;
        @(negedge clk);
        check("midframe_rst_out_valid", int'(ov[0]), 0);
        check("midframe_rst_out_data", int'(od[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_4x4(0, 1'b0);
        idle();
        idle();

        // clear together with pixel 3: the pixel is dropped, counters restart.
        send_pixel(0, 0, -1, 1'b0, 1'b0);
        send_pixel(0, 1, -1, 1'b0, 1'b0);
        send_pixel(0, 2, -1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        iv      = 4'b0001;
        in_data = DW'(3);
        clear   = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        iv    = '0;
        @(negedge clk);
        check("clear_out_valid", int'(ov[0]), 0);
        send_4x4(0, 1'b0);
        idle();
        idle();

        // Two frames back-to-back: 8 outputs, two out_last pulses.
        send_4x4(0, 1'b0);
        send_4x4(16, 1'b0);
        idle();
        idle();
        idle();

        check("pending_outputs_left", outq.size(), 0);
        check("pending_frame_done_left", fdq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected < 20000", cyc);
        $fatal(1, "timeout");
    end

endmodule
